// File: rtl/serial_chunk_adder_pkg.sv
// Shared constants for the serial chunk adder.
// FSM encodings and default operand/chunk sizes.
package serial_chunk_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/serial_chunk_adder_ripple.sv
// CHUNK-bit combinational ripple of full-adder cells.
// Also exports the carry into the MSB for signed overflow.
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c    = cin;
    cmsb = cin;
    sum  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end

  assign cout = c;

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/sub: one CHUNK-bit slice per clock, LSB first.
// Define SERIAL_ADDER_OVF_FLAG_EN to add the signed-overflow output ovf.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] ch_a, ch_b, ch_s;
  logic             ch_co, ch_cm;

  assign ch_a = a_q[idx_q*CHUNK +: CHUNK];
  assign ch_b = b_q[idx_q*CHUNK +: CHUNK];

  chunk_ripple_adder #(
    .CHUNK(CHUNK)
  ) u_ripple (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry_q),
    .sum  (ch_s),
    .cout (ch_co),
    .cmsb (ch_cm)
  );

`ifndef SERIAL_ADDER_OVF_FLAG_EN
  logic unused_cmsb;
  assign unused_cmsb = ch_cm;
`endif

  // Next-state: accept in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = ch_s;
        carry_d = ch_co;
        if (idx_q == LAST) begin
          cout_d  = ch_co;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
          ovf_d   = ch_cm ^ ch_co;
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench for serial_chunk_adder.
// Set CH to WIDTH for the single-chunk configuration.
module tb_serial_chunk_adder;

  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int NCH = W / CH;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
  logic         ovf;
`endif

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_chunk_adder #(
    .WIDTH(W),
    .CHUNK(CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta,
                                 input logic [W-1:0] tb,
                                 input logic tc,
                                 input logic ts);
    exp_t e;
    int   ua = int'(ta);
    int   ub = int'(tb);
    int   ic = int'(tc);
    int   sa = int'($signed(ta));
    int   sbv = int'($signed(tb));
    int   r;
    int   rs;
    if (!ts) begin
      r   = ua + ub + ic;
      e.c = (r > 65535);
      rs  = sa + sbv + ic;
    end else begin
      r   = ua - ub - ic;
      e.c = (r >= 0);
      rs  = sa - sbv - ic;
    end
    e.s = r[W-1:0];
    e.v = (rs > 32767) || (rs < -32768);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] ta,
                       input logic [W-1:0] tb,
                       input logic tc,
                       input logic ts);
    int w = 0;
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    sub = ts;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 32'(w < 20), 32'(1));
    @(posedge clk);
    sb.push_back(model(ta, tb, tc, ts));
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta;
    b = ta ^ tb;
    cin = ~tc;
    sub = ~ts;
  endtask

  task automatic get_result(input string tag, input int hold);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 50) begin
      chk({tag, "_rdy_run"}, 32'(in_ready), 32'(0));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NCH));
    chk({tag, "_sb"}, 32'(sb.size()), 32'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e.s));
      chk({tag, "_cout"}, 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.v));
`endif
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        a = W'($urandom);
        b = W'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_sum"}, 32'(sum), 32'(e.s));
        chk({tag, "_hold_cout"}, 32'(cout), 32'(e.c));
        chk({tag, "_hold_ov"}, 32'(out_valid), 32'(1));
        chk({tag, "_hold_rdy"}, 32'(in_ready), 32'(0));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'(0));
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    #2 rst = 1'b1;
    #2;
    chk("rst_ov", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'(1));

    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    get_result("add", 0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    get_result("ripple", 0);
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    get_result("sub_brw", 0);
    issue(16'h0007, 16'h0005, 1'b0, 1'b1);
    get_result("sub_ok", 0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    get_result("ovf", 0);
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    get_result("add_cin", 0);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1);
    get_result("sub_cin", 0);
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0);
    get_result("bp", 10);

    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'(0));
    chk("mid_rst_sum", 32'(sum), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    get_result("post_rst", 0);

    for (int k = 0; k < 8; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      issue(ra, rb, rc, rs);
      get_result("rand", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
